mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one single-ported memory between the CPU and a loader/DMA engine.
// Each access is a fixed-length transaction:
//   IDLE   -> pick an eligible requester (round-robin when both are eligible)
//   ACCESS -> memory selected for WAIT_STATES+1 cycles from latched registers
//   DONE   -> one-cycle completion pulse to the granted port, then IDLE
// A per-port "served" flag blocks a request that is still held after its
// completion pulse. The flag clears once that request has been seen low.
//
// Ports
//   clk            system clock, rising edge
//   ExternalReset  asynchronous reset, active low
//   ReadMem        CPU read request (level, held until MemDataready)
//   WriteMem       CPU write request (level, wins over ReadMem)
//   Addressbus     CPU address
//   cpu_wdata      CPU write data
//   Databus        CPU read data, holds until the next CPU read
//   MemDataready   CPU completion pulse
//   dma_req        DMA request (level, held until dma_ack)
//   dma_we         DMA direction, 1 = write
//   dma_addr       DMA address
//   dma_wdata      DMA write data
//   dma_rdata      DMA read data, holds until the next DMA read
//   dma_ack        DMA completion pulse
//   mem_cs         memory select
//   mem_we         memory write strobe
//   mem_addr       memory address (latched at grant)
//   mem_wdata      memory write data (latched at grant)
//   mem_rdata      memory read data
//   grant_dma      current or most recent owner, 0 = CPU, 1 = DMA
// ----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int WAIT_STATES = 2,
    parameter int AW          = 16,
    parameter int DW          = 16
) (
    input  logic          clk,
    input  logic          ExternalReset,
    input  logic          ReadMem,
    input  logic          WriteMem,
    input  logic [AW-1:0] Addressbus,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] Databus,
    output logic          MemDataready,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic          mem_cs,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          grant_dma
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [3:0] wait_cnt;
    logic       served_cpu;
    logic       served_dma;
    logic       write_op;

    logic       cpu_req;
    logic       cpu_elig;
    logic       dma_elig;
    logic       pick_dma;
    logic       pick_we;
    logic       start;
    logic       last_access;

    // ------------------------------------------------------------------
    // Arbitration terms
    // ------------------------------------------------------------------
    assign cpu_req  = ReadMem | WriteMem;
    assign cpu_elig = cpu_req & ~served_cpu;
    assign dma_elig = dma_req & ~served_dma;

    // DMA wins when it is the only eligible port, or when both are eligible
    // and the CPU held the bus last (grant_dma == 0).
    assign pick_dma = dma_elig & (~cpu_elig | ~grant_dma);
    assign pick_we  = pick_dma ? dma_we : WriteMem;

    assign last_access = (state == ACCESS) && (wait_cnt == 4'd0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        start      = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_elig || dma_elig) begin
                    state_next = ACCESS;
                    start      = 1'b1;
                end
            end
            ACCESS: begin
                if (wait_cnt == 4'd0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge ExternalReset) begin
        if (!ExternalReset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Wait-state down-counter: loaded at grant, ACCESS ends when it is 0
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge ExternalReset) begin
        if (!ExternalReset) begin
            wait_cnt <= 4'd0;
        end else if (start) begin
            wait_cnt <= WAIT_LOAD;
        end else if ((state == ACCESS) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Grant and transaction latches. Reset leaves grant_dma at 1 so the
    // first tie after reset goes to the CPU.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge ExternalReset) begin
        if (!ExternalReset) begin
            grant_dma <= 1'b1;
            write_op  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (start) begin
            grant_dma <= pick_dma;
            write_op  <= pick_we;
            mem_addr  <= pick_dma ? dma_addr  : Addressbus;
            mem_wdata <= pick_dma ? dma_wdata : cpu_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Registered strobes, derived from the next state so they line up
    // exactly with the ACCESS and DONE windows.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge ExternalReset) begin
        if (!ExternalReset) begin
            mem_cs       <= 1'b0;
            mem_we       <= 1'b0;
            MemDataready <= 1'b0;
            dma_ack      <= 1'b0;
        end else begin
            mem_cs       <= (state_next == ACCESS);
            // At the grant edge the latched direction is not yet valid,
            // so use the direction being latched.
            mem_we       <= (state_next == ACCESS) && (start ? pick_we : write_op);
            MemDataready <= (state_next == DONE) && !grant_dma;
            dma_ack      <= (state_next == DONE) &&  grant_dma;
        end
    end

    // ------------------------------------------------------------------
    // Read-data capture on the final ACCESS edge
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge ExternalReset) begin
        if (!ExternalReset) begin
            Databus   <= '0;
            dma_rdata <= '0;
        end else if (last_access && !write_op) begin
            if (grant_dma) begin
                dma_rdata <= mem_rdata;
            end else begin
                Databus <= mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Served flags: set on entering DONE, cleared whenever the request is
    // seen low. Setting takes priority since the request is still high then.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge ExternalReset) begin
        if (!ExternalReset) begin
            served_cpu <= 1'b0;
            served_dma <= 1'b0;
        end else begin
            if (last_access && !grant_dma) begin
                served_cpu <= 1'b1;
            end else if (!cpu_req) begin
                served_cpu <= 1'b0;
            end
            if (last_access && grant_dma) begin
                served_dma <= 1'b1;
            end else if (!dma_req) begin
                served_dma <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ----------------------------------------------------------------------------
// Testbench for mem_bus_arbiter. A transaction-level reference model tracks
// how many cycles the current transfer has been running and derives every
// expected output from that count.
// ----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int W  = 2;
    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rd = 1'b0;
    logic          wr = 1'b0;
    logic [AW-1:0] abus = '0;
    logic [DW-1:0] cwd = '0;
    logic [DW-1:0] db;
    logic          rdy;
    logic          dreq = 1'b0;
    logic          dwe = 1'b0;
    logic [AW-1:0] daddr = '0;
    logic [DW-1:0] dwd = '0;
    logic [DW-1:0] drd;
    logic          ack;
    logic          cs;
    logic          we;
    logic [AW-1:0] maddr;
    logic [DW-1:0] mwd;
    logic [DW-1:0] mrd = '0;
    logic          gnt;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.WAIT_STATES(W), .AW(AW), .DW(DW)) dut (
        .clk          (clk),
        .ExternalReset(rst_n),
        .ReadMem      (rd),
        .WriteMem     (wr),
        .Addressbus   (abus),
        .cpu_wdata    (cwd),
        .Databus      (db),
        .MemDataready (rdy),
        .dma_req      (dreq),
        .dma_we       (dwe),
        .dma_addr     (daddr),
        .dma_wdata    (dwd),
        .dma_rdata    (drd),
        .dma_ack      (ack),
        .mem_cs       (cs),
        .mem_we       (we),
        .mem_addr     (maddr),
        .mem_wdata    (mwd),
        .mem_rdata    (mrd),
        .grant_dma    (gnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: m_t = cycle number within the current transfer
    // (0 = no transfer, 1..W+1 = memory busy, W+2 = completion cycle).
    int            m_t;
    bit            m_owner;
    bit            m_write;
    bit            m_last;
    bit            m_srv_c;
    bit            m_srv_d;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_db;
    logic [DW-1:0] m_dr;
    bit            e_cs, e_we, e_rdy, e_ack, e_gnt;

    task automatic model_outputs();
        e_cs  = (m_t >= 1) && (m_t <= W + 1);
        e_we  = e_cs && m_write;
        e_rdy = (m_t == W + 2) && !m_owner;
        e_ack = (m_t == W + 2) &&  m_owner;
        e_gnt = m_last;
    endtask

    task automatic model_reset();
        m_t = 0; m_owner = 1'b0; m_write = 1'b0; m_last = 1'b1;
        m_srv_c = 1'b0; m_srv_d = 1'b0;
        m_addr = '0; m_wdata = '0; m_db = '0; m_dr = '0;
        model_outputs();
    endtask

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic model_step();
        bit creq, set_c, set_d, ec, ed;
        creq = rd | wr; set_c = 1'b0; set_d = 1'b0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_t == 0) begin
            ec = creq && !m_srv_c;
            ed = dreq && !m_srv_d;
            if (ec || ed) begin
                m_owner = (ec && ed) ? !m_last : ed;
                m_last  = m_owner;
                m_write = m_owner ? dwe : wr;
                m_addr  = m_owner ? daddr : abus;
                m_wdata = m_owner ? dwd : cwd;
                m_t = 1;
            end
        end else if (m_t <= W) begin
            m_t++;
        end else if (m_t == W + 1) begin
            if (!m_write) begin
                if (m_owner) m_dr = mrd;
                else         m_db = mrd;
            end
            if (m_owner) set_d = 1'b1;
            else         set_c = 1'b1;
            m_t = W + 2;
        end else begin
            m_t = 0;
        end
        m_srv_c = set_c ? 1'b1 : (creq ? m_srv_c : 1'b0);
        m_srv_d = set_d ? 1'b1 : (dreq ? m_srv_d : 1'b0);
        model_outputs();
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; rd = 1'b0; wr = 1'b0; dreq = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if ({cs, we, rdy, ack} !== 4'b0000) begin
            n_fail++; $display("FAIL reset_strobes: got %b expected 0000", {cs, we, rdy, ack});
        end
        n_checks++;
        if ({db, drd} !== 32'h0) begin
            n_fail++; $display("FAIL reset_rdata: got %h/%h expected 0000/0000", db, drd);
        end
        n_checks++;
        if ({maddr, mwd} !== 32'h0) begin
            n_fail++; $display("FAIL reset_mem_bus: got %h/%h expected 0000/0000", maddr, mwd);
        end
        n_checks++;
        if (gnt !== 1'b1) begin
            n_fail++; $display("FAIL reset_grant: got %b expected 1", gnt);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_cpu_read();
        int cs_cnt, rdy_at, rdy_cnt;
        cs_cnt = 0; rdy_at = -1; rdy_cnt = 0;
        rd = 1'b1; wr = 1'b0; abus = 16'h0010; mrd = 16'hBEEF; dreq = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_checks++;
            if ({cs, rdy} !== {e_cs, e_rdy}) begin
                n_fail++; $display("FAIL read_cycle%0d: got cs/rdy %b expected %b", k, {cs, rdy}, {e_cs, e_rdy});
            end
            if (cs) begin
                cs_cnt++;
                n_checks++;
                if (maddr !== 16'h0010) begin
                    n_fail++; $display("FAIL read_addr: got %h expected 0010", maddr);
                end
            end
            if (rdy) begin
                rdy_cnt++;
                if (rdy_at < 0) rdy_at = k;
                rd = 1'b0;
            end
        end
        n_checks++;
        if (cs_cnt != W + 1) begin
            n_fail++; $display("FAIL read_cs_len: got %0d expected %0d", cs_cnt, W + 1);
        end
        n_checks++;
        if (rdy_at != W + 2) begin
            n_fail++; $display("FAIL read_latency: got %0d expected %0d", rdy_at, W + 2);
        end
        n_checks++;
        if (rdy_cnt != 1) begin
            n_fail++; $display("FAIL read_pulses: got %0d expected 1", rdy_cnt);
        end
        mrd = 16'h5555;
        step(); step(); step();
        n_checks++;
        if (db !== 16'hBEEF) begin
            n_fail++; $display("FAIL read_data_hold: got %h expected BEEF", db);
        end
    endtask

    task automatic test_tie();
        logic gq[$];
        int   pulses;
        logic prev_cs;
        pulses = 0; prev_cs = 1'b0;
        do_reset();
        rd = 1'b1; wr = 1'b0; abus = 16'h0040;
        dreq = 1'b1; dwe = 1'b0; daddr = 16'h0100;
        for (int k = 1; k <= 20; k++) begin
            step();
            n_checks++;
            if ({cs, rdy, ack, gnt} !== {e_cs, e_rdy, e_ack, e_gnt}) begin
                n_fail++; $display("FAIL tie_cycle%0d: got %b expected %b", k, {cs, rdy, ack, gnt}, {e_cs, e_rdy, e_ack, e_gnt});
            end
            if (cs && !prev_cs) gq.push_back(gnt);
            prev_cs = cs;
            if (rdy) begin pulses++; rd = 1'b0; end
            if (ack) begin pulses++; dreq = 1'b0; end
        end
        n_checks++;
        if (gq.size() != 2) begin
            n_fail++; $display("FAIL tie_grants: got %0d grants expected 2", gq.size());
        end else begin
            n_checks++;
            if ({gq[0], gq[1]} !== 2'b01) begin
                n_fail++; $display("FAIL tie_order: got %b expected 01", {gq[0], gq[1]});
            end
        end
        n_checks++;
        if (pulses != 2) begin
            n_fail++; $display("FAIL tie_pulses: got %0d expected 2", pulses);
        end
    endtask

    task automatic test_write_priority();
        int we_cnt;
        we_cnt = 0;
        rd = 1'b1; wr = 1'b1; abus = 16'h0020; cwd = 16'h1234;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (we) begin
                we_cnt++;
                n_checks++;
                if ({maddr, mwd} !== {16'h0020, 16'h1234}) begin
                    n_fail++; $display("FAIL write_bus: got %h/%h expected 0020/1234", maddr, mwd);
                end
            end
            // Inputs wander during the access; the latched values must not.
            if (cs) begin abus = 16'($urandom); cwd = 16'($urandom); end
            if (rdy) begin rd = 1'b0; wr = 1'b0; end
        end
        n_checks++;
        if (we_cnt != W + 1) begin
            n_fail++; $display("FAIL write_we_len: got %0d expected %0d", we_cnt, W + 1);
        end
        n_checks++;
        if (db !== m_db) begin
            n_fail++; $display("FAIL write_databus: got %h expected %h", db, m_db);
        end
    endtask

    task automatic test_hold();
        bit seen;
        seen = 1'b0;
        rd = 1'b1; wr = 1'b0; abus = 16'h0030; mrd = 16'hA5A5;
        for (int k = 0; k < 10 && !seen; k++) begin
            step();
            if (rdy) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL hold_first_pulse: got none expected one");
        end
        for (int k = 0; k < 2; k++) begin
            step();
            n_checks++;
            if ({cs, rdy} !== 2'b00) begin
                n_fail++; $display("FAIL hold_no_reserve%0d: got cs/rdy %b expected 00", k, {cs, rdy});
            end
        end
        rd = 1'b0;
        step();
        n_checks++;
        if (cs !== 1'b0) begin
            n_fail++; $display("FAIL hold_low_cycle: got cs %b expected 0", cs);
        end
        rd = 1'b1;
        step();
        n_checks++;
        if (cs !== 1'b1) begin
            n_fail++; $display("FAIL hold_rearm: got cs %b expected 1", cs);
        end
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            step();
            if (rdy) begin seen = 1'b1; rd = 1'b0; end
        end
        n_checks++;
        if (!seen || db !== 16'hA5A5) begin
            n_fail++; $display("FAIL hold_second_read: got pulse %b data %h expected 1 A5A5", seen, db);
        end
        rd = 1'b0;
    endtask

    task automatic test_back_to_back();
        int   starts[$];
        logic gs[$];
        logic prev_cs;
        prev_cs = 1'b0;
        do_reset();
        rd = 1'b1; wr = 1'b0; dreq = 1'b1; dwe = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (cs && !prev_cs) begin starts.push_back(k); gs.push_back(gnt); end
            prev_cs = cs;
            rd   = ~rdy;
            dreq = ~ack;
        end
        n_checks++;
        if (starts.size() < 6) begin
            n_fail++; $display("FAIL b2b_count: got %0d accesses expected at least 6", starts.size());
        end else begin
            n_checks++;
            if (gs[0] !== 1'b0) begin
                n_fail++; $display("FAIL b2b_first: got grant %b expected 0", gs[0]);
            end
            for (int i = 1; i < starts.size(); i++) begin
                n_checks++;
                if (starts[i] - starts[i-1] != W + 3 || gs[i] === gs[i-1]) begin
                    n_fail++; $display("FAIL b2b_step%0d: got spacing %0d grant %b after %b expected %0d alternating",
                                       i, starts[i] - starts[i-1], gs[i], gs[i-1], W + 3);
                end
            end
        end
        rd = 1'b0; dreq = 1'b0;
        for (int k = 0; k < 8; k++) step();
    endtask

    task automatic test_reset_mid_access();
        int   acks, first_rdy, first_ack;
        logic prev_cs, first_gnt;
        bit   got_gnt;
        acks = 0; first_rdy = -1; first_ack = -1; prev_cs = 1'b0; first_gnt = 1'b1; got_gnt = 1'b0;
        do_reset();
        dreq = 1'b1; dwe = 1'b1; daddr = 16'h0055; dwd = 16'h7777;
        step();
        n_checks++;
        if ({cs, we} !== 2'b11) begin
            n_fail++; $display("FAIL rst_mid_setup: got cs/we %b expected 11", {cs, we});
        end
        step();
        rd = 1'b1;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({cs, we} !== 2'b00) begin
            n_fail++; $display("FAIL rst_mid_async: got cs/we %b expected 00", {cs, we});
        end
        for (int k = 0; k < 2; k++) begin
            step();
            if (ack) acks++;
        end
        n_checks++;
        if (acks != 0) begin
            n_fail++; $display("FAIL rst_mid_no_ack: got %0d acks expected 0", acks);
        end
        rst_n = 1'b1;
        model_reset();
        for (int k = 1; k <= 20; k++) begin
            step();
            if (cs && !prev_cs && !got_gnt) begin first_gnt = gnt; got_gnt = 1'b1; end
            prev_cs = cs;
            if (rdy) begin rd = 1'b0; if (first_rdy < 0) first_rdy = k; end
            if (ack) begin dreq = 1'b0; acks++; if (first_ack < 0) first_ack = k; end
        end
        n_checks++;
        if (!got_gnt || first_gnt !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_tie: got grant %b expected 0", first_gnt);
        end
        n_checks++;
        if (acks != 1 || first_rdy < 0 || first_ack < first_rdy) begin
            n_fail++; $display("FAIL rst_mid_order: got acks %0d rdy@%0d ack@%0d expected 1 ack after rdy",
                               acks, first_rdy, first_ack);
        end
        rd = 1'b0; dreq = 1'b0;
    endtask

    task automatic test_random();
        bit c_on, c_wait, d_on, d_wait;
        int c_left, d_left;
        c_on = 1'b0; c_wait = 1'b0; d_on = 1'b0; d_wait = 1'b0; c_left = 0; d_left = 0;
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            step();
            n_checks++;
            if ({cs, we, rdy, ack, gnt} !== {e_cs, e_we, e_rdy, e_ack, e_gnt}) begin
                n_fail++; $display("FAIL rand_ctrl@%0d: got cs/we/rdy/ack/gnt %b expected %b",
                                   k, {cs, we, rdy, ack, gnt}, {e_cs, e_we, e_rdy, e_ack, e_gnt});
            end
            n_checks++;
            if ({db, drd} !== {m_db, m_dr}) begin
                n_fail++; $display("FAIL rand_rdata@%0d: got %h/%h expected %h/%h", k, db, drd, m_db, m_dr);
            end
            n_checks++;
            if ({maddr, mwd} !== {m_addr, m_wdata}) begin
                n_fail++; $display("FAIL rand_mem_bus@%0d: got %h/%h expected %h/%h", k, maddr, mwd, m_addr, m_wdata);
            end
            // CPU requester: hold until the pulse, then 0..2 extra cycles.
            if (c_on) begin
                if (c_wait && rdy) begin c_wait = 1'b0; c_left = int'($urandom_range(0, 2)); end
                if (!c_wait) begin
                    if (c_left == 0) begin c_on = 1'b0; rd = 1'b0; wr = 1'b0; end
                    else c_left--;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                c_on = 1'b1; c_wait = 1'b1;
                rd = 1'($urandom_range(0, 1));
                wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (d_on) begin
                if (d_wait && ack) begin d_wait = 1'b0; d_left = int'($urandom_range(0, 2)); end
                if (!d_wait) begin
                    if (d_left == 0) begin d_on = 1'b0; dreq = 1'b0; end
                    else d_left--;
                end
            end else if ($urandom_range(0, 2) == 0) begin
                d_on = 1'b1; d_wait = 1'b1; dreq = 1'b1;
                dwe = 1'($urandom_range(0, 1));
            end
            abus  = 16'($urandom); cwd = 16'($urandom);
            daddr = 16'($urandom); dwd = 16'($urandom);
            mrd   = 16'($urandom);
        end
        rd = 1'b0; wr = 1'b0; dreq = 1'b0;
    endtask

    initial begin
        model_reset();
        test_reset();
        test_cpu_read();
        test_tie();
        test_write_priority();
        test_hold();
        test_back_to_back();
        test_reset_mid_access();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before the end of the test sequence");
        $fatal(1, "time limit");
    end

endmodule
